// File: rtl/ex_muldiv_pkg.sv
// Shared MDU definitions: datapath width, mul/div op encodings and the
// sequencer state encoding used by ex_muldiv.
package ex_muldiv_pkg;

  localparam int XLEN      = 64;
  localparam int MDUOP_LEN = 3;

  localparam logic [MDUOP_LEN-1:0] MDUOP_MUL    = 3'd0;
  localparam logic [MDUOP_LEN-1:0] MDUOP_MULH   = 3'd1;
  localparam logic [MDUOP_LEN-1:0] MDUOP_MULHSU = 3'd2;
  localparam logic [MDUOP_LEN-1:0] MDUOP_MULHU  = 3'd3;
  localparam logic [MDUOP_LEN-1:0] MDUOP_DIV    = 3'd4;
  localparam logic [MDUOP_LEN-1:0] MDUOP_DIVU   = 3'd5;
  localparam logic [MDUOP_LEN-1:0] MDUOP_REM    = 3'd6;
  localparam logic [MDUOP_LEN-1:0] MDUOP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] divisor_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  // rem_i < divisor keeps diff within W bits when it fits, so the top bit is the borrow
  assign q_o     = ~diff[W];
  assign rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier;
// divide stays iterative in both builds.
//
// state | meaning
// IDLE  | waiting for a mul/div from ID/EX
// BUSY  | one radix-2 step per cycle, counter counts down to 1
// DONE  | result_o valid for this cycle only
module ex_muldiv #(
  parameter int XLEN = ex_muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_valid_i,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_req_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  import ex_muldiv_pkg::*;

  localparam int CW   = $clog2(XLEN) + 1;
  localparam int WLEN = 32;

  mdu_state_e state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [2*XLEN-1:0]    mcand;   // multiplicand, or divisor in the low half
  logic [XLEN-1:0]      mplier;  // multiplier, or dividend shifting into quotient
  logic [2*XLEN-1:0]    prod;    // product, or partial remainder in the low half
  logic [MDUOP_LEN-1:0] op_q;
  logic                 word_q, neg_q, sign_a_q, bypass_q;

  logic            is_div, a_signed, b_signed, accept;
  logic [XLEN-1:0] opa, opb, abs_a, abs_b, min_neg, special_res;
  logic            sa, sb, div_zero, div_ovf, special;
  logic [XLEN-1:0] rem_nxt;
  logic            q_bit;
  logic [2*XLEN-1:0] fast_prod;
  logic              fast_mul;

  assign is_div   = op_i[2];
  assign a_signed = (op_i == MDUOP_MULH) | (op_i == MDUOP_MULHSU) |
                    (op_i == MDUOP_DIV)  | (op_i == MDUOP_REM);
  assign b_signed = (op_i == MDUOP_MULH) | (op_i == MDUOP_DIV) | (op_i == MDUOP_REM);

  // word ops see only the low 32 bits, extended according to operand signedness
  assign opa = word_i ? (a_signed ? {{(XLEN-WLEN){rs1_data_i[WLEN-1]}}, rs1_data_i[WLEN-1:0]}
                                  : {{(XLEN-WLEN){1'b0}}, rs1_data_i[WLEN-1:0]})
                      : rs1_data_i;
  assign opb = word_i ? (b_signed ? {{(XLEN-WLEN){rs2_data_i[WLEN-1]}}, rs2_data_i[WLEN-1:0]}
                                  : {{(XLEN-WLEN){1'b0}}, rs2_data_i[WLEN-1:0]})
                      : rs2_data_i;

  assign sa    = a_signed & opa[XLEN-1];
  assign sb    = b_signed & opb[XLEN-1];
  assign abs_a = sa ? -opa : opa;
  assign abs_b = sb ? -opb : opb;

  assign min_neg  = word_i ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = is_div & (opb == '0);
  assign div_ovf  = is_div & b_signed & (opa == min_neg) & (&opb);
  assign special  = div_zero | div_ovf;
  // op_i[1] distinguishes REM* from DIV*
  assign special_res = div_zero ? (op_i[1] ? opa : '1)
                                : (op_i[1] ? '0 : opa);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
  assign fast_mul  = ~is_div;
`else
  assign fast_prod = '0;
  assign fast_mul  = 1'b0;
`endif

  assign accept = (state == MDU_IDLE) & valid_i & ~flush_valid_i;

  mdu_div_step #(.W(XLEN)) u_div_step (
    .rem_i     (prod[XLEN-1:0]),
    .divisor_i (mcand[XLEN-1:0]),
    .bit_i     (mplier[XLEN-1]),
    .rem_o     (rem_nxt),
    .q_o       (q_bit)
  );

  // result formatting from the final accumulator contents
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   mul_hi, mul_res, div_res, res_full, res_fmt;

  assign prod_signed = neg_q ? -prod : prod;
  assign mul_hi   = word_q ? {{(XLEN-WLEN){1'b0}}, prod_signed[2*WLEN-1:WLEN]}
                           : prod_signed[2*XLEN-1:XLEN];
  assign mul_res  = (op_q[1:0] == 2'b00) ? prod_signed[XLEN-1:0] : mul_hi;
  assign div_res  = op_q[1] ? (sign_a_q ? -prod[XLEN-1:0] : prod[XLEN-1:0])
                            : (neg_q ? -mplier : mplier);
  assign res_full = bypass_q ? prod[XLEN-1:0] : (op_q[2] ? div_res : mul_res);
  assign res_fmt  = word_q ? {{(XLEN-WLEN){res_full[WLEN-1]}}, res_full[WLEN-1:0]}
                           : res_full;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nxt;
  end

  // next-state and outputs; flush overrides everything
  always_comb begin
    state_nxt      = state;
    stall_req_o    = 1'b0;
    result_valid_o = 1'b0;
    result_o       = '0;
    busy_o         = (state != MDU_IDLE);
    case (state)
      MDU_IDLE: begin
        stall_req_o = accept;
        if (accept) state_nxt = (special | fast_mul) ? MDU_DONE : MDU_BUSY;
      end
      MDU_BUSY: begin
        stall_req_o = ~flush_valid_i;
        if (cnt == CW'(1)) state_nxt = MDU_DONE;
      end
      MDU_DONE: begin
        result_valid_o = ~flush_valid_i;
        result_o       = res_fmt;
        state_nxt      = MDU_IDLE;
      end
      default: state_nxt = MDU_IDLE;
    endcase
    if (flush_valid_i) state_nxt = MDU_IDLE;
  end

  // operand capture at accept, then one shift-add or shift-subtract per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      bypass_q <= 1'b0;
    end else if (accept) begin
      op_q     <= op_i;
      word_q   <= word_i;
      sign_a_q <= sa;
      neg_q    <= sa ^ sb;
      bypass_q <= special;
      cnt      <= word_i ? CW'(WLEN) : CW'(XLEN);
      if (special) begin
        prod   <= {{XLEN{1'b0}}, special_res};
        mcand  <= '0;
        mplier <= '0;
      end else if (is_div) begin
        prod   <= '0;
        mcand  <= {{XLEN{1'b0}}, abs_b};
        // word dividends start at the top so the step always consumes bit XLEN-1
        mplier <= word_i ? (abs_a << WLEN) : abs_a;
      end else begin
        prod   <= fast_prod;
        mcand  <= {{XLEN{1'b0}}, abs_a};
        mplier <= abs_b;
      end
    end else if (state == MDU_BUSY) begin
      cnt <= cnt - CW'(1);
      if (op_q[2]) begin
        prod   <= {{XLEN{1'b0}}, rem_nxt};
        mplier <= {mplier[XLEN-2:0], q_bit};
      end else begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule
